// File: rtl/cube_timer_pkg.sv
// Shared definitions for the cube-move timing blocks: timer state encoding,
// default count width and the prescaler width helper.
package cube_timer_pkg;

    // Two-state controller: IDLE waits for a start, RUN counts down.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam int TIMER_WIDTH_DEFAULT = 4;

    // Prescaler counter width; a divide-by-one still keeps a one-bit register
    // so the sub-module never ends up with a zero-width vector.
    function automatic int prescale_bits(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable divider for the countdown timer. Counts qualified ena cycles and
// raises tick on every PRESCALE-th one. tick is combinational from the count
// and ena so that the owning FSM can act on the same edge the divider wraps.
module tick_prescaler
    import cube_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clkf,
    input  logic rst,
    input  logic clr,
    input  logic ena,
    output logic tick
);

    localparam int              PW   = prescale_bits(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = ena && (cnt == LAST);

    // Advance on each ena cycle, wrap to zero on tick; clr restarts the divide.
    always_ff @(posedge clkf) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter for step delays and fixed-length pulses.
// A start in IDLE loads load_val and enters RUN; each prescaler tick
// decrements countout, and reaching zero raises a one-cycle done.
// Optional feature macro: COUNTDOWN_TIMER_AUTORELOAD_EN -- when defined the
// terminal decrement reloads the start value and keeps running, giving a
// periodic done until stop or rst.
module countdown_timer
    import cube_timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic             clkf,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] countout,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_state_t     state;
    timer_state_t     state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic             running;
    logic             pre_ena;
    logic             pre_clr;
    logic             tick;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nxt;
`endif

    assign running = (state == RUN);
    assign busy    = running;

    // The divider only runs while counting; it is held clear in IDLE so every
    // load starts from a fresh prescale period, and a stop clears it as well.
    assign pre_clr = !running || stop;
    assign pre_ena = ena && running && !stop;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clkf (clkf),
        .rst  (rst),
        .clr  (pre_clr),
        .ena  (pre_ena),
        .tick (tick)
    );

    // Next-state logic: stop beats the terminal decrement, which beats start.
    // The terminal test uses <= 1 so the count can never step below zero.
    always_comb begin
        state_nxt = state;
        count_nxt = countout;
        done_nxt  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        reload_nxt = reload_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        count_nxt = load_val;
                        state_nxt = RUN;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        reload_nxt = load_val;
`endif
                    end else begin
                        count_nxt = '0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (countout <= ONE) begin
                        done_nxt = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        count_nxt = reload_q;
`else
                        count_nxt = '0;
                        state_nxt = IDLE;
`endif
                    end else begin
                        count_nxt = countout - ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Register every output-facing value so nothing reaches the ports
    // combinationally from the inputs.
    always_ff @(posedge clkf) begin
        if (rst) begin
            state    <= IDLE;
            countout <= '0;
            done     <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state    <= state_nxt;
            countout <= count_nxt;
            done     <= done_nxt;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q <= reload_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer. Two instances share the clock and
// reset: dut1 with PRESCALE=1 and dut3 with PRESCALE=3. Expected outputs are
// queued as stimulus is driven and drained just after the following edge.
module tb_countdown_timer;

    logic       clkf;
    logic       rst;

    logic       ena1, start1, stop1;
    logic [3:0] load1, count1;
    logic       busy1, done1;

    logic       ena3, start3, stop3;
    logic [3:0] load3, count3;
    logic       busy3, done3;

    typedef struct {
        string      tag;
        bit         sel3;
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t sbq[$];
    int   passCount  = 0;
    int   checkCount = 0;

    countdown_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clkf(clkf), .rst(rst), .ena(ena1), .start(start1), .stop(stop1),
        .load_val(load1), .countout(count1), .busy(busy1), .done(done1)
    );

    countdown_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clkf(clkf), .rst(rst), .ena(ena3), .start(start3), .stop(stop3),
        .load_val(load3), .countout(count3), .busy(busy3), .done(done3)
    );

    initial clkf = 1'b0;
    always #5 clkf = ~clkf;

    task automatic applyStimulus(input bit sel3, input logic st, input logic sp,
                                 input logic en, input logic [3:0] lv);
        if (sel3) begin
            start3 = st; stop3 = sp; ena3 = en; load3 = lv;
        end else begin
            start1 = st; stop1 = sp; ena1 = en; load1 = lv;
        end
    endtask

    task automatic pushExp(input string tag, input bit sel3, input logic [3:0] c,
                           input logic b, input logic d);
        exp_t e;
        e.tag = tag; e.sel3 = sel3; e.cnt = c; e.bsy = b; e.dn = d;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [5:0] obs;
        logic [5:0] want;
        while (sbq.size() > 0) begin
            e    = sbq.pop_front();
            obs  = e.sel3 ? {count3, busy3, done3} : {count1, busy1, done1};
            want = {e.cnt, e.bsy, e.dn};
            checkCount++;
            assert (obs === want) passCount++;
            else $error("FAIL %s: observed cnt=%0d busy=%b done=%b, expected cnt=%0d busy=%b done=%b",
                        e.tag, obs[5:2], obs[1], obs[0], want[5:2], want[1], want[0]);
        end
    endtask

    // One rising edge, then sample 1 time unit later and drain the queue.
    task automatic clockCycle();
        @(posedge clkf);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 4'd0);
        applyStimulus(1, 0, 0, 0, 4'd0);
        pushExp("reset1", 0, 4'd0, 0, 0);
        pushExp("reset3", 1, 4'd0, 0, 0);
        clockCycle();
        rst = 1'b0;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        // Periodic run: 3,2,1,3(done),2,1,3(done),2 then stop.
        applyStimulus(0, 1, 0, 1, 4'd3);
        pushExp("arLoad", 0, 4'd3, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd3);
        for (int k = 1; k <= 7; k++) begin
            pushExp("arRun", 0, 4'(3 - (k % 3)), 1, (k % 3) == 0);
            clockCycle();
        end
        applyStimulus(0, 0, 1, 1, 4'd3);
        pushExp("arStop", 0, 4'd2, 0, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd3);
        pushExp("arIdle", 0, 4'd2, 0, 0);
        clockCycle();
`else
        // Plain run from 5 with PRESCALE=1.
        applyStimulus(0, 1, 0, 1, 4'd5);
        pushExp("run5Load", 0, 4'd5, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd5);
        for (int i = 4; i >= 1; i--) begin
            pushExp("run5Count", 0, 4'(i), 1, 0);
            clockCycle();
        end
        pushExp("run5Done", 0, 4'd0, 0, 1);
        clockCycle();
        pushExp("run5DoneOnce", 0, 4'd0, 0, 0);
        clockCycle();

        // PRESCALE=3, load 2, ena held high: done 6 edges after the load.
        applyStimulus(1, 1, 0, 1, 4'd2);
        pushExp("pre3Load", 1, 4'd2, 1, 0);
        clockCycle();
        applyStimulus(1, 0, 0, 1, 4'd2);
        for (int k = 1; k <= 5; k++) begin
            pushExp("pre3Count", 1, (k < 3) ? 4'd2 : 4'd1, 1, 0);
            clockCycle();
        end
        pushExp("pre3Done", 1, 4'd0, 0, 1);
        clockCycle();

        // PRESCALE=3, ena toggling 0/1 after the load: done 12 edges later.
        applyStimulus(1, 1, 0, 1, 4'd2);
        pushExp("pre3TogLoad", 1, 4'd2, 1, 0);
        clockCycle();
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(1, 0, 0, (k % 2) == 0, 4'd2);
            pushExp("pre3TogCount", 1, (k < 6) ? 4'd2 : 4'd1, 1, 0);
            clockCycle();
        end
        applyStimulus(1, 0, 0, 1, 4'd2);
        pushExp("pre3TogDone", 1, 4'd0, 0, 1);
        clockCycle();
        applyStimulus(1, 0, 0, 0, 4'd0);

        // Zero load: immediate done, never busy.
        applyStimulus(0, 1, 0, 1, 4'd0);
        pushExp("zeroLoad", 0, 4'd0, 0, 1);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd0);
        pushExp("zeroLoadOnce", 0, 4'd0, 0, 0);
        clockCycle();

        // Start ignored in RUN, then stop at 3.
        applyStimulus(0, 1, 0, 1, 4'd5);
        pushExp("stopLoad", 0, 4'd5, 1, 0);
        clockCycle();
        applyStimulus(0, 1, 0, 1, 4'd9);
        pushExp("startIgnored", 0, 4'd4, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd9);
        pushExp("stopPre", 0, 4'd3, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 1, 1, 4'd9);
        pushExp("stopAt3", 0, 4'd3, 0, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd9);
        pushExp("stopHold", 0, 4'd3, 0, 0);
        clockCycle();

        // Stop coinciding with the 1->0 decrement: count stays 1, no done.
        applyStimulus(0, 1, 0, 1, 4'd2);
        pushExp("stopTermLoad", 0, 4'd2, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd2);
        pushExp("stopTermPre", 0, 4'd1, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 1, 1, 4'd2);
        pushExp("stopTerm", 0, 4'd1, 0, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd2);
        pushExp("stopTermHold", 0, 4'd1, 0, 0);
        clockCycle();

        // ena low holds state; then reset mid-run at 4.
        applyStimulus(0, 1, 0, 0, 4'd4);
        pushExp("holdLoad", 0, 4'd4, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 0, 4'd4);
        pushExp("enaLowHold", 0, 4'd4, 1, 0);
        clockCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 4'd4);
        pushExp("midRunReset", 0, 4'd0, 0, 0);
        clockCycle();
        rst = 1'b0;
        pushExp("afterReset", 0, 4'd0, 0, 0);
        clockCycle();

        // Restart accepted in the very cycle done is high.
        applyStimulus(0, 1, 0, 1, 4'd1);
        pushExp("backLoad1", 0, 4'd1, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd1);
        pushExp("backDone1", 0, 4'd0, 0, 1);
        clockCycle();
        applyStimulus(0, 1, 0, 1, 4'd2);
        pushExp("backReload", 0, 4'd2, 1, 0);
        clockCycle();
        applyStimulus(0, 0, 0, 1, 4'd2);
        pushExp("backCount", 0, 4'd1, 1, 0);
        clockCycle();
        pushExp("backDone2", 0, 4'd0, 0, 1);
        clockCycle();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that runs in the opposite direction to the free-running up-counter in the display/sequencing path. It accepts a start count, decrements it on qualified enable ticks, and reports completion with a one-cycle `done` pulse. Cube-move sequencing uses it for step delays and fixed-length pulses. Single clock domain, synchronous active-high reset.

## Interface
- `WIDTH`, default 4: count width in bits, ≥ 2.
- `PRESCALE`, default 1: number of qualified `ena` ticks per decrement, ≥ 1.

- `clkf`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous active-high reset.
- `ena`  in  1: tick enable; only cycles with `ena`=1 advance the prescaler.
- `start`  in  1: load `load_val` and begin counting; sampled only in IDLE.
- `stop`  in  1: abort counting, return to IDLE, hold `countout`.
- `load_val`  in  WIDTH: start value, unsigned.
- `countout`  out  WIDTH: current count; bit WIDTH-1 is the MSB.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when the count reaches 0.

## Operation
- States: IDLE and RUN. Reset forces IDLE, `countout`=0, prescaler=0, `busy`=0, `done`=0.
- IDLE, `start`=1, `load_val`≠0: `countout`←`load_val`, prescaler←0, go to RUN.
- IDLE, `start`=1, `load_val`=0: `countout`←0, `done` pulses next cycle, stay IDLE.
- RUN, `ena`=1: prescaler increments. When prescaler = PRESCALE-1, it wraps to 0 and `countout` decrements by 1. With PRESCALE=1, every `ena` cycle decrements.
- RUN decrement from 1 to 0: `done`=1 in the same registered update, go to IDLE (default build).
- RUN, `ena`=0: all state held.
- `start` in RUN: ignored; no restart, no reload.
- `stop`=1 in RUN: go to IDLE next cycle, keep `countout`, prescaler←0, no `done`.
- Priority: `rst` > `stop` > terminal decrement > `start`. If `stop` and the terminal decrement coincide, `stop` wins: no `done`, and `countout` keeps its pre-edge value of 1.
- No underflow. `countout` never wraps from 0 to all-ones in any configuration.
- Arithmetic is unsigned, WIDTH bits. The prescaler is $clog2(PRESCALE) bits, minimum 1.

## Timing
- `start` sampled at edge t: `busy`=1 and `countout`=`load_val` are visible after edge t.
- With `ena` held at 1 and load value N: `countout`=0 and `done`=1 after edge t+N·PRESCALE; `busy`=0 in that same cycle.
- `done` is exactly one cycle wide. A new `start` is accepted in the cycle `done` is high, since the block is already in IDLE.
- `rst` during RUN: after the next edge all outputs are at their reset values and no `done` is issued.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- Macro `COUNTDOWN_TIMER_AUTORELOAD_EN`.
- Defined: a reload register captures `load_val` on an accepted `start`. On the terminal decrement, `done` pulses, `countout` is reloaded from the reload register instead of going to 0, and the block stays in RUN. This gives a periodic `done` every N·PRESCALE `ena` cycles. Only `stop` or `rst` leave RUN.
- Not defined: no reload register; the terminal decrement returns to IDLE with `countout`=0.

## Structure
- Shared package `cube_timer_pkg` holds:
  - the state enumeration `timer_state_t` with values IDLE and RUN;
  - the constant `TIMER_WIDTH_DEFAULT`=4.
- One sub-module, `tick_prescaler`: the `ena` divider. It outputs a one-cycle `tick` every PRESCALE `ena` cycles and has a synchronous clear. The top-level FSM decrements only on `tick`.

## Test plan
- Reset and run: after `rst`, pulse `start` with `load_val`=5, `ena`=1, PRESCALE=1. Expect `countout` 5,4,3,2,1,0 on successive cycles, `done` high only in the cycle with 0, and `busy` low from that cycle on.
- Prescaled run: PRESCALE=3, `load_val`=2, `ena`=1. Expect `done` exactly 6 cycles after the load cycle; with `ena` toggling 1/0, expect 12 cycles.
- Zero load: `start` with `load_val`=0. Expect `busy` never high, `countout`=0, and a single `done` pulse one cycle later.
- Stop and start interactions:
  - `stop` at `countout`=3: count holds at 3, `busy` drops, no `done`.
  - `start` with `load_val`=9 during RUN: ignored.
  - `stop` coinciding with the 1→0 decrement: `countout` stays 1, no `done`.
- Mid-run reset: `rst` at `countout`=4. Next cycle `countout`=0, `busy`=0, `done`=0.
- Auto-reload: with `COUNTDOWN_TIMER_AUTORELOAD_EN` defined, `load_val`=3, `ena`=1. Expect `done` every 3 cycles, `countout` sequence 3,2,1,3,2,1…, and `busy` staying high until `stop`.
